// File: rtl/pwm_cmd_parser_pkg.sv
// ---------------------------------------------------------------------------
// pwm_cmd_parser_pkg
// Shared definitions for the PWM command parser: ASCII constants used by the
// command grammar and the acknowledge path, FSM state encoding, field widths
// and the default duty ceiling. Small helpers classify received bytes.
// ---------------------------------------------------------------------------
package pwm_cmd_parser_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_D_UC = 8'h44;
    localparam logic [7:0] ASCII_D_LC = 8'h64;
    localparam logic [7:0] ASCII_P_UC = 8'h50;
    localparam logic [7:0] ASCII_P_LC = 8'h70;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_E    = 8'h45;

    localparam int DUTY_W       = 7;
    localparam int POW_W        = 2;
    localparam int ACC_W        = 10;
    localparam int DUTY_MAX_DEF = 100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DUTY  = 2'd1,
        ST_POW   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/pwm_cmd_timer.sv
// ---------------------------------------------------------------------------
// pwm_cmd_timer
// Inter-byte timeout counter. Counts while run=1, restarts on clr, and pulses
// expired for one cycle when the count reaches CYCLES-1. CYCLES=0 disables
// expiry entirely.
// Ports:
//   clk     in  system clock
//   rstn    in  asynchronous active-low reset
//   run     in  count enable (counter held at 0 when low)
//   clr     in  restart count (a byte arrived)
//   expired out one-cycle timeout pulse
// ---------------------------------------------------------------------------
module pwm_cmd_timer #(
    parameter int unsigned CYCLES = 500000
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned LIMIT = (CYCLES == 0) ? 0 : CYCLES - 1;
    localparam int          W     = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM_V = W'(LIMIT);
    localparam logic         EN    = (CYCLES != 0);

    logic [W-1:0] r_cnt;
    logic         w_at_limit;

    assign w_at_limit = (r_cnt == LIM_V);
    // clr suppresses expiry so an arriving byte always wins over the timeout.
    assign expired    = EN && run && !clr && w_at_limit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!run || clr || w_at_limit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_cmd_parser.sv
// ---------------------------------------------------------------------------
// pwm_cmd_parser
// Parses line-terminated ASCII commands from the UART receiver and holds the
// PWM settings. "D<1..3 digits>" sets duty_percent, "P<x><y>" sets pow2/pow5.
// Terminator is CR or LF; letters are case-insensitive.
// Optional macro PWM_CMD_ACK_EN adds a 'K'/'E' acknowledge byte output.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rx_data, rx_valid    received byte + one-cycle strobe (no backpressure)
//   tx_data, tx_valid,
//   tx_ready             (PWM_CMD_ACK_EN only) acknowledge byte handshake:
//                        tx_valid holds until a cycle with tx_valid&&tx_ready
//   duty_percent         registered duty 0..DUTY_MAX
//   pow2, pow5           registered divider exponents
//   upd, cmd_ok, cmd_err one-cycle strobes
// ---------------------------------------------------------------------------
module pwm_cmd_parser
    import pwm_cmd_parser_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TIMEOUT_MS = 10,
    parameter int unsigned DUTY_MAX   = DUTY_MAX_DEF,
    parameter int unsigned DUTY_RST   = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
`ifdef PWM_CMD_ACK_EN
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
`endif
    output logic [DUTY_W-1:0]   duty_percent,
    output logic [POW_W-1:0]    pow2,
    output logic [POW_W-1:0]    pow5,
    output logic                upd,
    output logic                cmd_ok,
    output logic                cmd_err
);

    localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam logic [ACC_W-1:0] DUTY_MAX_V = ACC_W'(DUTY_MAX);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [1:0]         r_cnt, w_cnt_nxt;
    logic [POW_W-1:0]   r_x, w_x_nxt, r_y, w_y_nxt;
    logic [DUTY_W-1:0]  r_duty;
    logic [POW_W-1:0]   r_pow2, r_pow5;
    logic               r_upd, r_ok, r_err;
    logic               w_ok, w_err, w_set_duty, w_set_pow;
    logic               w_expired, w_digit, w_term;
    logic [3:0]         w_dval;

    // For '0'..'9' (0x30..0x39) the low nibble is the digit value.
    assign w_dval  = rx_data[3:0];
    assign w_digit = is_digit(rx_data);
    assign w_term  = is_term(rx_data);

    pwm_cmd_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .run     (r_state != ST_IDLE),
        .clr     (rx_valid),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_set_duty  = 1'b0;
        w_set_pow   = 1'b0;
        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == ASCII_D_UC || rx_data == ASCII_D_LC) begin
                        w_state_nxt = ST_DUTY;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (rx_data == ASCII_P_UC || rx_data == ASCII_P_LC) begin
                        w_state_nxt = ST_POW;
                        w_cnt_nxt   = '0;
                    end else if (!w_term) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_DUTY: begin
                    if (w_digit) begin
                        if (r_cnt == 2'd3) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            // acc*10 + d as shift-and-add
                            w_acc_nxt = {r_acc[ACC_W-4:0], 3'b000}
                                      + {r_acc[ACC_W-2:0], 1'b0}
                                      + {{(ACC_W-4){1'b0}}, w_dval};
                            w_cnt_nxt = r_cnt + 2'd1;
                        end
                    end else if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        if (r_cnt == 2'd0 || r_acc > DUTY_MAX_V) begin
                            w_err = 1'b1;
                        end else begin
                            w_ok       = 1'b1;
                            w_set_duty = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_POW: begin
                    if (w_digit) begin
                        if (r_cnt == 2'd2 || w_dval > 4'd3) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            if (r_cnt == 2'd0) w_x_nxt = w_dval[1:0];
                            else               w_y_nxt = w_dval[1:0];
                            w_cnt_nxt = r_cnt + 2'd1;
                        end
                    end else if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        if (r_cnt != 2'd2) begin
                            w_err = 1'b1;
                        end else begin
                            w_ok      = 1'b1;
                            w_set_pow = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                default: begin
                    if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end
                end
            endcase
        end else if (w_expired) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_duty  <= DUTY_W'(DUTY_RST);
            r_pow2  <= '0;
            r_pow5  <= '0;
            r_upd   <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_upd   <= w_set_duty | w_set_pow;
            r_ok    <= w_ok;
            r_err   <= w_err;
            if (w_set_duty) r_duty <= r_acc[DUTY_W-1:0];
            if (w_set_pow) begin
                r_pow2 <= r_x;
                r_pow5 <= r_y;
            end
        end
    end

    assign duty_percent = r_duty;
    assign pow2         = r_pow2;
    assign pow5         = r_pow5;
    assign upd          = r_upd;
    assign cmd_ok       = r_ok;
    assign cmd_err      = r_err;

`ifdef PWM_CMD_ACK_EN
    logic [7:0] r_tx_data;
    logic       r_tx_valid;

    // A completion always wins over a same-cycle handshake: latest result stays pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_ok || w_err) begin
            r_tx_data  <= w_ok ? ASCII_K : ASCII_E;
            r_tx_valid <= 1'b1;
        end else if (r_tx_valid && tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
`endif

endmodule

// File: tb/tb_pwm_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_pwm_cmd_parser
// Directed bench for pwm_cmd_parser. Each command pushes its expected strobe
// response onto exp_q; a negedge monitor pops and compares whenever the DUT
// raises upd/cmd_ok/cmd_err. The timeout is shortened to 40 cycles.
// ---------------------------------------------------------------------------
module tb_pwm_cmd_parser;

    localparam int RSP_W = 14;  // {cmd_ok, cmd_err, upd, duty[6:0], pow2, pow5}

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [6:0] duty_percent;
    logic [1:0] pow2, pow5;
    logic       upd, cmd_ok, cmd_err;
`ifdef PWM_CMD_ACK_EN
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
`endif

    // ---- clock / reset ----
    always #5 clk = ~clk;

    pwm_cmd_parser #(
        .CLK_FREQ   (1000),
        .TIMEOUT_MS (40),
        .DUTY_MAX   (100),
        .DUTY_RST   (0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
`ifdef PWM_CMD_ACK_EN
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
`endif
        .duty_percent (duty_percent),
        .pow2         (pow2),
        .pow5         (pow5),
        .upd          (upd),
        .cmd_ok       (cmd_ok),
        .cmd_err      (cmd_err)
    );

    // ---- scoreboard state ----
    int               n_cmp = 0;
    int               n_fail = 0;
    logic [RSP_W-1:0] exp_q[$];
    logic [RSP_W-1:0] mon_got, mon_exp;
    logic [6:0]       m_duty = 7'd0;
    logic [1:0]       m_p2 = 2'd0, m_p5 = 2'd0;
    bit               mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---- monitor ----
    always @(negedge clk) begin
        if (mon_en && (cmd_ok || cmd_err || upd)) begin
            mon_got = {cmd_ok, cmd_err, upd, duty_percent, pow2, pow5};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got %h, required no strobe", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL strobe_response: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    // ---- expectation helpers ----
    task automatic exp_duty(input logic [6:0] d);
        m_duty = d;
        exp_q.push_back({3'b101, m_duty, m_p2, m_p5});
    endtask

    task automatic exp_pow(input logic [1:0] x, input logic [1:0] y);
        m_p2 = x;
        m_p5 = y;
        exp_q.push_back({3'b101, m_duty, m_p2, m_p5});
    endtask

    task automatic exp_err();
        exp_q.push_back({3'b010, m_duty, m_p2, m_p5});
    endtask

    // ---- driver ----
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run(input string body, input logic [7:0] term);
        send_str(body);
        send_byte(term);
    endtask

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_duty", 32'(duty_percent), 32'd0);
        check("rst_pow2", 32'(pow2), 32'd0);
        check("rst_pow5", 32'(pow5), 32'd0);
        check("rst_strobes", 32'({upd, cmd_ok, cmd_err}), 32'd0);
        rstn   = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_strobes", 32'({upd, cmd_ok, cmd_err}), 32'd0);

        // basic commands; trailing LF after CR is silent
        exp_duty(7'd75); run("D75", CR);
        send_byte(LF);
        exp_pow(2'd2, 2'd1); run("P21", LF);
        exp_pow(2'd1, 2'd3); run("p13", LF);

        // errors, settings unchanged
        exp_err(); run("D101", LF);
        exp_err(); run("D1234", LF);
        exp_err(); run("D", LF);
        exp_err(); run("P4 0", LF);
        exp_err(); run("X9", LF);
        check("err_duty_kept", 32'(duty_percent), 32'd75);
        check("err_pow_kept", 32'({pow2, pow5}), 32'({2'd1, 2'd3}));

        // boundaries and value rules
        exp_duty(7'd100); run("D100", CR);
        exp_duty(7'd7);   run("d007", LF);
        exp_duty(7'd7);   run("D7", LF);
        exp_pow(2'd3, 2'd3); run("P33", CR);
        exp_err(); run("P3", LF);
        exp_err(); run("P123", LF);
        exp_duty(7'd0);   run("D0", LF);
        send_byte(CR);
        send_byte(LF);

        // timeout on a partial command, then a stray digit goes through FLUSH
        exp_err(); send_str("D5");
        repeat (60) @(negedge clk);
        check("timeout_duty_kept", 32'(duty_percent), 32'd0);
        exp_err(); run("0", LF);

        // gaps shorter than the timeout keep the command alive
        exp_duty(7'd42);
        send_byte("D");
        repeat (30) @(negedge clk);
        send_byte("4");
        repeat (30) @(negedge clk);
        run("2", CR);

`ifdef PWM_CMD_ACK_EN
        tx_ready = 1'b0;
        exp_duty(7'd30); run("D30", LF);
        exp_err();       run("D200", LF);
        repeat (2) @(negedge clk);
        check("ack_data", 32'(tx_data), 32'h45);
        check("ack_valid_held", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("ack_valid_cleared", 32'(tx_valid), 32'd0);
        tx_ready = 1'b1;
`endif

        // reset mid-command aborts silently and restores reset values
        send_str("D9");
        @(negedge clk);
        rstn = 1'b0;
        m_duty = 7'd0; m_p2 = 2'd0; m_p5 = 2'd0;
        repeat (2) @(negedge clk);
        check("abort_duty", 32'(duty_percent), 32'd0);
        check("abort_pow", 32'({pow2, pow5}), 32'd0);
        rstn = 1'b1;
        send_byte(LF);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_settings", 32'({duty_percent, pow2, pow5}), 32'({m_duty, m_p2, m_p5}));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_cmd_parser.md
Name: pwm_cmd_parser

Overview:
- Upstream control stage for pwm_core / pwm_divider.
- Consumes ASCII bytes from the UART receiver (8N1, 115200 baud, 50 MHz system) and parses line-terminated commands.
- Holds the registered settings duty_percent, pow2 and pow5 that drive the PWM datapath.
- Reports command success/failure with single-cycle strobes.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz; used only to derive the timeout.
- TIMEOUT_MS, 10, inter-byte timeout in ms while a command is partial; 0 disables the timeout.
- DUTY_MAX, 100, largest legal duty value.
- DUTY_RST, 0, duty_percent value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; always accepted, no backpressure.
- duty_percent  out  7  registered duty, 0..DUTY_MAX.
- pow2  out  2  registered divider exponent of 2.
- pow5  out  2  registered divider exponent of 5.
- upd  out  1  one-cycle strobe when any setting register is written.
- cmd_ok  out  1  one-cycle strobe when a command completes successfully.
- cmd_err  out  1  one-cycle strobe when a command is rejected or times out.

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset values: state=IDLE, duty_percent=DUTY_RST, pow2=0, pow5=0, upd=0, cmd_ok=0, cmd_err=0, accumulator=0, timer=0.
- Reset asserted mid-command aborts the command with no strobe.
- Command grammar (letters case-insensitive; terminator is CR 0x0D or LF 0x0A):
  - Duty command: 'D' followed by 1..3 decimal digits, then terminator.
  - Pow command: 'P' followed by exactly 2 digits x,y, each 0..3, then terminator. Sets pow2=x, pow5=y.
- States: IDLE, DUTY, POW, FLUSH.
- IDLE:
  - 'D'/'d' -> DUTY, clear accumulator and digit count.
  - 'P'/'p' -> POW, clear digit count.
  - CR/LF -> stay in IDLE silently, so CRLF pairs are harmless.
  - Any other byte -> FLUSH.
- DUTY:
  - Digit -> acc = acc*10 + digit, implemented as (acc<<3)+(acc<<1)+d in 10 bits; count++.
  - A 4th digit or any non-digit non-terminator -> FLUSH.
  - Terminator with count=0, or with acc>DUTY_MAX -> cmd_err, no update, -> IDLE.
  - Otherwise terminator -> duty_percent=acc[6:0], upd=1, cmd_ok=1, -> IDLE.
- POW:
  - 1st digit is latched as x, 2nd digit as y.
  - A digit >3, a 3rd digit, or a non-digit non-terminator -> FLUSH.
  - Terminator with count!=2 -> cmd_err, -> IDLE.
  - Otherwise terminator -> pow2=x, pow5=y, upd=1, cmd_ok=1, -> IDLE.
- FLUSH: discards bytes until a terminator, then cmd_err, -> IDLE.
- Latency: setting registers and strobes change on the rising edge that samples the terminator's rx_valid (1 cycle). Setting registers never change otherwise.
- Timeout:
  - TIMEOUT_CYCLES = CLK_FREQ/1000*TIMEOUT_MS.
  - The timer counts while state!=IDLE and clears on every rx_valid.
  - Reaching TIMEOUT_CYCLES-1 -> cmd_err, -> IDLE, no update.
  - If rx_valid and expiry coincide, the byte is processed and the timer clears (byte wins).
  - The timer is held at 0 in IDLE.
- Value rules:
  - An identical value rewritten still pulses upd.
  - cmd_ok and cmd_err are never high together.
  - Leading zeros are allowed ("D007" -> 7).

Optional Feature:
- Macro: PWM_CMD_ACK_EN.
- When defined, adds ports:
  - tx_data  out  8  acknowledge byte.
  - tx_valid  out  1  acknowledge byte pending.
  - tx_ready  in  1  downstream accepts the byte.
- Acknowledge behaviour:
  - Each command completion loads tx_data with 'K' (0x4B) on cmd_ok or 'E' (0x45) on cmd_err, and sets tx_valid.
  - tx_valid holds until a cycle with tx_valid&&tx_ready, then clears.
  - A new completion while pending overwrites tx_data with the latest result, and tx_valid stays high.
  - Completion and handshake in the same cycle: the new byte is loaded and tx_valid stays high.
  - Reset: tx_valid=0, tx_data=0.
- When undefined: tx ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared include pwm_defs.vh holds:
  - ASCII constants: CR, LF, 'D', 'd', 'P', 'p', '0', '9', 'K', 'E'.
  - State encodings.
  - DUTY_MAX default.
  - Widths for duty (7) and pow fields (2).
- One sub-module, pwm_cmd_timer: parameterised timeout counter with inputs clk, rstn, run, clr, and a one-cycle expired output.

Test Plan:
- Reset, no input -> duty=0, pow2=0, pow5=0, all strobes 0.
- Bytes "D75\r" -> 1 cycle after '\r': duty_percent=75, upd=1, cmd_ok=1 for one cycle. Following '\n' produces no strobe.
- "P21\n" then "p13\n" -> pow2=2/pow5=1, then pow2=1/pow5=3, each with cmd_ok.
- Errors, each giving one cmd_err pulse with settings unchanged:
  - "D101\n", "D1234\n", "D\n" (cmd_err, duty unchanged).
  - "P4 0\n", "X9\n" (cmd_err, pow unchanged).
- "D5", then 10 ms idle -> cmd_err at expiry, state IDLE. A following "0\n" -> cmd_err via FLUSH? No: '0' in IDLE -> FLUSH, then '\n' -> cmd_err. Duty unchanged.
- With PWM_CMD_ACK_EN, tx_ready=0, send "D30\n" then "D200\n" -> tx_data='E' with tx_valid held. Raising tx_ready for 1 cycle -> tx_valid=0 next cycle.
